pipe_skid_reg: RTL and testbench

//  Parametrised pipeline-stage register with valid/ready handshake, flush and optional 2-entry skid buffer.

---
 rtl/pipe_skid_reg_pkg.sv | 28 ++
 rtl/pipe_skid_reg_if.sv | 19 +
 rtl/pipe_skid_reg.sv | 164 ++++++++++++++++
 tb/tb_pipe_skid_reg.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// ----------------------------------------------------------------------------
// pipe_skid_reg_pkg
//   Shared definitions for the pipeline-stage register:
//     PIPE_NOP      default bubble payload (all-zero NOP)
//     pipe_state_t  entry-count state of the skid variant (EMPTY/ONE/TWO)
//     state_count   number of held entries for a given state
// ----------------------------------------------------------------------------
package pipe_skid_reg_pkg;

    localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    function automatic logic [1:0] state_count(input pipe_state_t s);
        logic [1:0] n;
        case (s)
            ONE:     n = 2'd1;
            TWO:     n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// ----------------------------------------------------------------------------
// pipe_skid_reg_if
//   One valid/ready/data link between two pipeline stages.
//     valid  producer has a live payload
//     ready  consumer accepts this cycle
//     data   payload, WIDTH bits
//   master: the producer side (drives valid/data, sees ready)
//   slave : the consumer side (sees valid/data, drives ready)
// ----------------------------------------------------------------------------
interface pipe_skid_reg_if #(
    parameter int WIDTH = 32
) ();
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_skid_reg.sv
// ----------------------------------------------------------------------------
// pipe_skid_reg
//   Pipeline-stage register with valid/ready handshake, flush and an optional
//   2-entry skid buffer. One instance per stage boundary.
//
//   Parameters
//     WIDTH   payload width
//     SKID    1: two entries, in_ready straight from a flop
//             0: one entry, in_ready = ~out_valid | out_ready (combinational)
//     BUBBLE  payload shown on out_data while out_valid is low
//
//   Ports
//     clk        clock, all state on posedge
//     rst        synchronous, active-high reset (wins over flush)
//     flush      discard every held entry; a coincident in transfer is lost,
//                a coincident out transfer completes normally
//     in_bus     upstream link (slave):   valid/data in, ready out
//     out_bus    downstream link (master): valid/data out, ready in
//     occupancy  registered count of held entries (0..2)
// ----------------------------------------------------------------------------
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter bit               SKID   = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(PIPE_NOP)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    pipe_skid_reg_if.slave  in_bus,
    pipe_skid_reg_if.master out_bus,
    output logic [1:0]      occupancy
);

    generate
        if (SKID) begin : g_skid
            pipe_state_t      state_reg, state_next;
            logic [WIDTH-1:0] main_reg;     // head entry
            logic [WIDTH-1:0] skid_reg;     // second entry, only meaningful in TWO
            logic             in_ready_reg;
            logic [1:0]       occ_reg;
            logic             in_xfer;
            logic             out_xfer;
            logic             load_main_in;
            logic             load_main_skid;
            logic             load_skid;

            assign in_xfer  = in_bus.valid & in_ready_reg;
            assign out_xfer = (state_reg != EMPTY) & out_bus.ready;

            always_comb begin
                state_next     = state_reg;
                load_main_in   = 1'b0;
                load_main_skid = 1'b0;
                load_skid      = 1'b0;
                case (state_reg)
                    EMPTY: begin
                        if (in_xfer) begin
                            state_next   = ONE;
                            load_main_in = 1'b1;
                        end
                    end
                    ONE: begin
                        if (in_xfer && out_xfer) begin
                            load_main_in = 1'b1;
                        end else if (in_xfer) begin
                            state_next = TWO;
                            load_skid  = 1'b1;
                        end else if (out_xfer) begin
                            state_next = EMPTY;
                        end
                    end
                    TWO: begin
                        // in_ready is low here, so only the drain can happen
                        if (out_xfer) begin
                            state_next     = ONE;
                            load_main_skid = 1'b1;
                        end
                    end
                    default: state_next = EMPTY;
                endcase
                // Flush kills everything, including an incoming word
                if (flush) begin
                    state_next     = EMPTY;
                    load_main_in   = 1'b0;
                    load_main_skid = 1'b0;
                    load_skid      = 1'b0;
                end
            end

            // in_ready and occupancy are precomputed from the next state so
            // both leave the stage as plain flop outputs.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg    <= EMPTY;
                    in_ready_reg <= 1'b1;
                    occ_reg      <= 2'd0;
                end else begin
                    state_reg    <= state_next;
                    in_ready_reg <= (state_next != TWO);
                    occ_reg      <= state_count(state_next);
                end
            end

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    main_reg <= BUBBLE;
                end else if (load_main_in) begin
                    main_reg <= in_bus.data;
                end else if (load_main_skid) begin
                    main_reg <= skid_reg;
                end
            end

            always_ff @(posedge clk) begin
                if (load_skid) begin
                    skid_reg <= in_bus.data;
                end
            end

            assign in_bus.ready  = in_ready_reg;
            assign out_bus.valid = (state_reg != EMPTY);
            // main_reg can be stale after the last entry drains
            assign out_bus.data  = (state_reg != EMPTY) ? main_reg : BUBBLE;
            assign occupancy     = occ_reg;
        end else begin : g_single
            logic             full_reg;
            logic [WIDTH-1:0] main_reg;
            logic             in_ready_c;
            logic             in_xfer;
            logic             out_xfer;

            // Accept when empty or when the held word leaves this same cycle
            assign in_ready_c = ~full_reg | out_bus.ready;
            assign in_xfer    = in_bus.valid & in_ready_c;
            assign out_xfer   = full_reg & out_bus.ready;

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    full_reg <= 1'b0;
                end else if (in_xfer) begin
                    full_reg <= 1'b1;
                end else if (out_xfer) begin
                    full_reg <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    main_reg <= BUBBLE;
                end else if (in_xfer) begin
                    main_reg <= in_bus.data;
                end
            end

            assign in_bus.ready  = in_ready_c;
            assign out_bus.valid = full_reg;
            assign out_bus.data  = full_reg ? main_reg : BUBBLE;
            assign occupancy     = {1'b0, full_reg};
        end
    endgenerate

endmodule

// File: tb/tb_pipe_skid_reg.sv
// ----------------------------------------------------------------------------
// tb_pipe_skid_reg
//   Drives a SKID=1 instance (non-zero bubble) and a SKID=0 instance side by
//   side. Each has a queue model: a FIFO of capacity 2 (skid) or 1 (single)
//   that takes handshakes at the clock edge, pops on out transfer, clears on
//   flush/rst. Every cycle the outputs are compared with what the queue says.
// ----------------------------------------------------------------------------
module tb_pipe_skid_reg;

    localparam logic [31:0] S_BUBBLE = 32'hDEAD_0013;
    localparam logic [31:0] D_BUBBLE = 32'h0000_0000;

    logic       clk = 1'b0;
    logic       rst;
    logic       s_flush, d_flush;
    logic [1:0] s_occ, d_occ;

    pipe_skid_reg_if #(.WIDTH(32)) s_in ();
    pipe_skid_reg_if #(.WIDTH(32)) s_out ();
    pipe_skid_reg_if #(.WIDTH(32)) d_in ();
    pipe_skid_reg_if #(.WIDTH(32)) d_out ();

    pipe_skid_reg #(.WIDTH(32), .SKID(1'b1), .BUBBLE(S_BUBBLE)) dut_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (s_flush),
        .in_bus    (s_in),
        .out_bus   (s_out),
        .occupancy (s_occ)
    );

    pipe_skid_reg #(.WIDTH(32), .SKID(1'b0), .BUBBLE(D_BUBBLE)) dut_single (
        .clk       (clk),
        .rst       (rst),
        .flush     (d_flush),
        .in_bus    (d_in),
        .out_bus   (d_out),
        .occupancy (d_occ)
    );

    always #5 clk = ~clk;

    logic [31:0] q_s[$];
    logic [31:0] q_d[$];
    int n_checks  = 0;
    int n_pass    = 0;
    int cyc       = 0;
    int s_obs_cnt = 0, s_pop_cnt = 0;
    int d_obs_cnt = 0, d_pop_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, obs, exp);
        else
            n_pass++;
    endtask

    task automatic drive(input logic iv, input logic [31:0] id, input logic ordy);
        s_in.valid  = iv;
        s_in.data   = id;
        s_out.ready = ordy;
        d_in.valid  = iv;
        d_in.data   = id;
        d_out.ready = ordy;
    endtask

    // Compare outputs with the model, then advance one clock and the model.
    task automatic tick();
        logic        s_ir, d_ir;
        logic [31:0] s_hd, d_hd;
        #1;
        s_ir = (q_s.size() < 2);
        d_ir = (q_d.size() == 0) || d_out.ready;
        s_hd = (q_s.size() != 0) ? q_s[0] : S_BUBBLE;
        d_hd = (q_d.size() != 0) ? q_d[0] : D_BUBBLE;
        check("s_in_ready",  32'(s_in.ready),  32'(s_ir));
        check("s_out_valid", 32'(s_out.valid), 32'(q_s.size() != 0));
        check("s_out_data",  s_out.data,       s_hd);
        check("s_occupancy", 32'(s_occ),       32'(q_s.size()));
        check("d_in_ready",  32'(d_in.ready),  32'(d_ir));
        check("d_out_valid", 32'(d_out.valid), 32'(q_d.size() != 0));
        check("d_out_data",  d_out.data,       d_hd);
        check("d_occupancy", 32'(d_occ),       32'(q_d.size()));
        if (!rst && s_out.valid && s_out.ready) begin
            s_obs_cnt++;
            $display("cyc %0d skid   out %h", cyc, s_out.data);
        end
        if (!rst && d_out.valid && d_out.ready) begin
            d_obs_cnt++;
            $display("cyc %0d single out %h", cyc, d_out.data);
        end
        @(posedge clk);
        if (rst) begin
            q_s.delete();
            q_d.delete();
        end else begin
            if (q_s.size() != 0 && s_out.ready) begin
                void'(q_s.pop_front());
                s_pop_cnt++;
            end
            if (s_flush) q_s.delete();
            else if (s_in.valid && s_ir) q_s.push_back(s_in.data);
            if (q_d.size() != 0 && d_out.ready) begin
                void'(q_d.pop_front());
                d_pop_cnt++;
            end
            if (d_flush) q_d.delete();
            else if (d_in.valid && d_ir) q_d.push_back(d_in.data);
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; s_flush = 1'b0; d_flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);

        // T1: reset held for two more cycles, then idle
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();

        // T2: back-to-back stream with downstream always ready
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 1'b1);
            tick();
        end
        drive(1'b0, 32'h0, 1'b1);
        repeat (2) tick();

        // T3: fill under backpressure, then drain
        drive(1'b1, 32'hA, 1'b0); tick();
        drive(1'b1, 32'hB, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b0); tick();
        drive(1'b0, 32'h0, 1'b1);
        repeat (3) tick();

        // T4: flush while full, offered word must vanish
        drive(1'b1, 32'hA, 1'b0); tick();
        drive(1'b1, 32'hB, 1'b0); tick();
        s_flush = 1'b1; d_flush = 1'b1;
        drive(1'b1, 32'hC, 1'b0); tick();
        s_flush = 1'b0; d_flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        repeat (2) tick();
        // flush with accepted input and a completing output
        drive(1'b1, 32'h5, 1'b0); tick();
        s_flush = 1'b1; d_flush = 1'b1;
        drive(1'b1, 32'hC, 1'b1); tick();
        s_flush = 1'b0; d_flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        repeat (2) tick();

        // T5: single gets 1010 out_ready and random valid; skid gets fully
        // random traffic with occasional flush
        for (int k = 0; k < 500; k++) begin
            d_in.valid  = 1'($urandom_range(0, 1));
            d_in.data   = $urandom;
            d_out.ready = (k % 2 == 0);
            s_in.valid  = 1'($urandom_range(0, 1));
            s_in.data   = $urandom;
            s_out.ready = 1'($urandom_range(0, 1));
            s_flush     = ($urandom_range(0, 15) == 0);
            tick();
        end
        s_flush = 1'b0;
        drive(1'b0, 32'h0, 1'b1);
        repeat (3) tick();
        check("s_xfer_count", 32'(s_obs_cnt), 32'(s_pop_cnt));
        check("d_xfer_count", 32'(d_obs_cnt), 32'(d_pop_cnt));

        // T6: rst together with flush while full
        drive(1'b1, 32'hA, 1'b0); tick();
        drive(1'b1, 32'hB, 1'b0); tick();
        rst = 1'b1; s_flush = 1'b1; d_flush = 1'b1;
        drive(1'b1, 32'hC, 1'b1); tick();
        rst = 1'b0; s_flush = 1'b0; d_flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        repeat (2) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
